rmt_ingress_arbiter: RTL and testbench
======================================

// Module: rmt_ingress_arbiter
// PURPOSE
// - Two-port AXI-Stream packet arbiter in front of the RMT pipeline's s_axis input.
// - Merges two MAC-side 512-bit streams into one by whole packets, round-robin.
// - Stamps the source port ID into tuser and keeps per-port packet counters.
// - One register slice on the output: tvalid/tdata appear one cycle after input acceptance.
// PARAMETERS
// C_S_AXIS_DATA_WIDTH   512    tdata width; tkeep = C_S_AXIS_DATA_WIDTH/8
// C_S_AXIS_TUSER_WIDTH  128    tuser width
// SRC_PORT_LSB          16     LSB of the 8-bit source-port field in tuser
// PORT0_ID              8'h01  value written to the source-port field for port 0
// PORT1_ID              8'h04  value written to the source-port field for port 1
// PORTS
// clk              in   1     axis clock
// aresetn          in   1     asynchronous active-low reset
// s0_axis_tdata/tkeep/tuser/tvalid/tlast  in  DW/DW/8/UW/1/1  port 0 stream
// s0_axis_tready   out  1     port 0 ready
// s1_axis_tdata/tkeep/tuser/tvalid/tlast  in  DW/DW/8/UW/1/1  port 1 stream
// s1_axis_tready   out  1     port 1 ready
// m_axis_tdata/tkeep/tuser/tvalid/tlast   out DW/DW/8/UW/1/1  merged stream to the RMT
// m_axis_tready    in   1     downstream ready
// pkt_cnt_0        out  32    packets accepted from port 0
// pkt_cnt_1        out  32    packets accepted from port 1
// BEHAVIOUR
// - Reset (async, aresetn=0): state=IDLE, last_grant=1, m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0,
//   s0/s1_axis_tready=0, pkt_cnt_0=pkt_cnt_1=0. Applies immediately, including mid-packet;
//   the partial packet is discarded and the output slice is emptied.
// - FSM states: IDLE, PASS0, PASS1.
//   IDLE: only s0 valid -> PASS0; only s1 valid -> PASS1; both valid -> the port != last_grant.
//     Neither valid -> stay. No input is accepted in IDLE.
//   PASSn: accept beats from port n only; on an accepted beat with tlast=1 -> IDLE, last_grant=n.
//   There is one idle cycle between packets. This is decided; no same-cycle re-arbitration.
// - Slice free: slot_free = !m_axis_tvalid || m_axis_tready.
// - Ready: sN_axis_tready = (state==PASSN) && slot_free. The other port's ready is held at 0.
// - Accepted beat (sN_tvalid && sN_tready): the output register loads tdata/tkeep/tlast.
//   tuser is loaded with tuser[SRC_PORT_LSB+7:SRC_PORT_LSB] replaced by PORTn_ID.
//   All other tuser bits pass through unchanged. m_axis_tvalid is set to 1.
// - Output register: m_axis_tvalid is cleared when m_axis_tready=1 and no new beat is loaded
//   in that cycle. While m_axis_tvalid && !m_axis_tready, the outputs are held stable.
// - Latency: 1 cycle from input acceptance to m_axis_tvalid. Full throughput within a packet.
// - Counters: pkt_cnt_N increments on each accepted port-N beat with tlast=1.
//   Modulo 2^32: 32'hFFFFFFFF -> 0, with no saturation.
// - Packets are never interleaved. Beat order within a packet is preserved. No beats are
//   dropped or duplicated under any backpressure pattern.
// - Fairness: under continuous contention the grants strictly alternate 0,1,0,1.
// TESTING
// 1. Reset release, s0 sends a 3-beat packet and m_ready=1 -> 3 output beats 1 cycle delayed.
//    tuser[23:16]=8'h01, last beat has tlast=1, pkt_cnt_0=1.
// 2. s0 and s1 both hold valid packets from reset -> port 0 served first, then port 1.
//    Grant order 0,1,0,1 over 4 packets, each packet contiguous, with one idle cycle between.
// 3. Toggle m_ready randomly (50%) during a 5-beat s1 packet -> 5 beats out, data matches,
//    outputs stable while stalled, s0_tready=0 throughout.
// 4. Force pkt_cnt_1 to 32'hFFFFFFFF, send one s1 packet -> pkt_cnt_1=0 and pkt_cnt_0 unchanged.
// 5. Assert aresetn=0 mid-way (beat 2 of 4) -> m_tvalid=0 and both treadys=0 immediately.
//    After release, a new s1 packet passes intact with tuser[23:16]=8'h04.
// 6. s1 tuser=128'hFFFF..FF -> output tuser differs only in [23:16]=8'h04.

Source files
------------

// File: rtl/rmt_ingress_arbiter.sv
// Two-port AXI-Stream packet arbiter feeding the RMT s_axis input.
// Whole-packet round-robin merge, source-port stamping, packet counters.
module rmt_ingress_arbiter #(
    parameter int         C_S_AXIS_DATA_WIDTH  = 512,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter int         SRC_PORT_LSB         = 16,
    parameter logic [7:0] PORT0_ID             = 8'h01,
    parameter logic [7:0] PORT1_ID             = 8'h04
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    input  logic                              s0_axis_tlast,
    output logic                              s0_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    input  logic                              s1_axis_tlast,
    output logic                              s1_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [31:0]                       pkt_cnt_0,
    output logic [31:0]                       pkt_cnt_1
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic [KW-1:0]   keep_q, keep_d;
    logic [UW-1:0]   user_q, user_d;
    logic            last_q, last_d;
    logic            valid_q, valid_d;
    logic [31:0]     pkt_cnt_0_q, pkt_cnt_0_d;
    logic [31:0]     pkt_cnt_1_q, pkt_cnt_1_d;

    logic            slot_free;
    logic            acc0, acc1;
    logic [UW-1:0]   user0_stamped, user1_stamped;

    // Handshake: only the granted port sees ready, and only when the slice can take a beat
    always_comb begin
        slot_free      = !valid_q || m_axis_tready;
        s0_axis_tready = (state_q == PASS0) && slot_free;
        s1_axis_tready = (state_q == PASS1) && slot_free;
        acc0           = s0_axis_tvalid && s0_axis_tready;
        acc1           = s1_axis_tvalid && s1_axis_tready;
    end

    // Overwrite the source-port byte of tuser, pass every other bit through
    always_comb begin
        user0_stamped = s0_axis_tuser;
        user1_stamped = s1_axis_tuser;
        user0_stamped[SRC_PORT_LSB +: 8] = PORT0_ID;
        user1_stamped[SRC_PORT_LSB +: 8] = PORT1_ID;
    end

    // Packet-level grant FSM; a grant is only released on an accepted tlast beat
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    state_d = last_grant_q ? PASS0 : PASS1;
                end else if (s0_axis_tvalid) begin
                    state_d = PASS0;
                end else if (s1_axis_tvalid) begin
                    state_d = PASS1;
                end
            end
            PASS0: begin
                if (acc0 && s0_axis_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            PASS1: begin
                if (acc1 && s1_axis_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register slice: load on acceptance, drain on downstream ready, else hold
    always_comb begin
        data_d  = data_q;
        keep_d  = keep_q;
        user_d  = user_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (acc0) begin
            data_d  = s0_axis_tdata;
            keep_d  = s0_axis_tkeep;
            user_d  = user0_stamped;
            last_d  = s0_axis_tlast;
            valid_d = 1'b1;
        end else if (acc1) begin
            data_d  = s1_axis_tdata;
            keep_d  = s1_axis_tkeep;
            user_d  = user1_stamped;
            last_d  = s1_axis_tlast;
            valid_d = 1'b1;
        end else if (m_axis_tready) begin
            valid_d = 1'b0;
        end
    end

    // Per-port packet counters, free-running modulo 2^32
    always_comb begin
        pkt_cnt_0_d = pkt_cnt_0_q;
        pkt_cnt_1_d = pkt_cnt_1_q;
        if (acc0 && s0_axis_tlast) begin
            pkt_cnt_0_d = pkt_cnt_0_q + 32'd1;
        end
        if (acc1 && s1_axis_tlast) begin
            pkt_cnt_1_d = pkt_cnt_1_q + 32'd1;
        end
    end

    // State and datapath registers; reset drops any partial packet and empties the slice
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            keep_q       <= '0;
            user_q       <= '0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
            pkt_cnt_0_q  <= '0;
            pkt_cnt_1_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            user_q       <= user_d;
            last_q       <= last_d;
            valid_q      <= valid_d;
            pkt_cnt_0_q  <= pkt_cnt_0_d;
            pkt_cnt_1_q  <= pkt_cnt_1_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = valid_q;
    assign pkt_cnt_0     = pkt_cnt_0_q;
    assign pkt_cnt_1     = pkt_cnt_1_q;

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Directed bench for rmt_ingress_arbiter.
// Output beats are collected by a negedge monitor and compared to expected lists.
module tb_rmt_ingress_arbiter;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
    logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
    logic [UW-1:0] s0_tuser = '0, s1_tuser = '0;
    logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic          s0_tready, s1_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid, m_tlast;
    logic          m_tready = 1'b1;
    logic [31:0]   pkt_cnt_0, pkt_cnt_1;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;

    beat_t         obs[$];
    int            obs_cyc[$];
    beat_t         expq[$];
    logic          stall = 1'b0;
    beat_t         prev = '0;

    rmt_ingress_arbiter dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tkeep  (s0_tkeep),
        .s0_axis_tuser  (s0_tuser),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tlast  (s0_tlast),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tkeep  (s1_tkeep),
        .s1_axis_tuser  (s1_tuser),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tlast  (s1_tlast),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tuser   (m_tuser),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .pkt_cnt_0      (pkt_cnt_0),
        .pkt_cnt_1      (pkt_cnt_1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [767:0] o,
                       input logic [767:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic beat_t cur_out();
        beat_t b;
        b.d = m_tdata;
        b.k = m_tkeep;
        b.u = m_tuser;
        b.l = m_tlast;
        return b;
    endfunction

    // Capture transfers and verify outputs hold while stalled
    always @(negedge clk) begin
        if (!aresetn) begin
            stall <= 1'b0;
        end else begin
            if (stall) chk("stall_stable", 768'(cur_out()), 768'(prev));
            stall <= m_tvalid && !m_tready;
            prev  <= cur_out();
            if (m_tvalid && m_tready) begin
                obs.push_back(cur_out());
                obs_cyc.push_back(cyc);
            end
        end
    end

    function automatic beat_t mk(input int port, input logic [31:0] tag,
                                 input int i, input int n,
                                 input logic [UW-1:0] u, input bit st);
        beat_t b;
        b.d = {16{tag + 32'(i)}};
        b.k = (i == n - 1) ? {32'h0, 32'hFFFF_FFFF} : '1;
        b.l = (i == n - 1);
        b.u = u;
        if (st) b.u[23:16] = (port == 1) ? 8'h04 : 8'h01;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input beat_t b, input logic v);
        if (port == 0) begin
            s0_tdata = b.d; s0_tkeep = b.k; s0_tuser = b.u;
            s0_tlast = b.l; s0_tvalid = v;
        end else begin
            s1_tdata = b.d; s1_tkeep = b.k; s1_tuser = b.u;
            s1_tlast = b.l; s1_tvalid = v;
        end
    endtask

    // Present npk packets of nb beats each, holding valid until accepted
    task automatic send(input int port, input int npk, input int nb,
                        input logic [31:0] tag, input logic [UW-1:0] u);
        for (int p = 0; p < npk; p++) begin
            for (int i = 0; i < nb; i++) begin
                logic acc;
                int   t;
                drive(port, mk(port, tag + 32'(p * 16), i, nb, u, 1'b0), 1'b1);
                acc = 1'b0;
                t = 0;
                while (!acc && t < 200) begin
                    @(negedge clk);
                    acc = (port == 1) ? s1_tready : s0_tready;
                    @(posedge clk);
                    #1;
                    t++;
                end
                if (!acc) chk("send_timeout", 768'(t), 768'(0));
            end
        end
        drive(port, '0, 1'b0);
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, 768'(obs.size()), 768'(expq.size()));
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 768'(obs[i]), 768'(expq[i]));
        end
    endtask

    task automatic rst();
        aresetn = 1'b0;
        drive(0, '0, 1'b0);
        drive(1, '0, 1'b0);
        m_tready = 1'b1;
        repeat (2) step();
        aresetn = 1'b1;
        obs.delete();
        obs_cyc.delete();
        expq.delete();
    endtask

    initial begin
        logic [UW-1:0] u1;
        logic [UW-1:0] uu;
        beat_t b;
        bit done;

        // Reset state
        #1;
        chk("rst_mvalid", 768'(m_tvalid), 768'(0));
        chk("rst_s0rdy", 768'(s0_tready), 768'(0));
        chk("rst_s1rdy", 768'(s1_tready), 768'(0));
        chk("rst_cnts", 768'({pkt_cnt_0, pkt_cnt_1}), 768'(0));
        chk("rst_mout", 768'(cur_out()), 768'(0));

        // 1: s0 3-beat packet, 1-cycle latency
        rst();
        u1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        drive(0, mk(0, 32'h100, 0, 3, u1, 1'b0), 1'b1);
        chk("t1_idle_rdy", 768'(s0_tready), 768'(0));
        step();
        chk("t1_grant_rdy", 768'({s0_tready, s1_tready}), 768'(2'b10));
        chk("t1_no_out", 768'(m_tvalid), 768'(0));
        step();
        chk("t1_b0_valid", 768'(m_tvalid), 768'(1));
        chk("t1_b0_data", 768'(m_tdata), 768'({16{32'h100}}));
        chk("t1_b0_user", 768'(m_tuser),
            768'(128'h0123_4567_89AB_CDEF_0011_2233_4401_6677));
        chk("t1_b0_last", 768'(m_tlast), 768'(0));
        drive(0, mk(0, 32'h100, 1, 3, u1, 1'b0), 1'b1);
        step();
        chk("t1_b1_data", 768'(m_tdata), 768'({16{32'h101}}));
        drive(0, mk(0, 32'h100, 2, 3, u1, 1'b0), 1'b1);
        step();
        chk("t1_b2_data", 768'(m_tdata), 768'({16{32'h102}}));
        chk("t1_b2_last", 768'({m_tlast, m_tkeep}),
            768'({1'b1, 64'h0000_0000_FFFF_FFFF}));
        chk("t1_cnt0", 768'(pkt_cnt_0), 768'(1));
        chk("t1_rdy_drop", 768'(s0_tready), 768'(0));
        drive(0, '0, 1'b0);
        step();
        chk("t1_drain", 768'(m_tvalid), 768'(0));

        // 2: contention from reset, 2 packets per port of 2 beats
        rst();
        uu = 128'hA5;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++)
                expq.push_back(mk(0, 32'h200 + 32'(p * 16), i, 2, uu, 1'b1));
            for (int i = 0; i < 2; i++)
                expq.push_back(mk(1, 32'h300 + 32'(p * 16), i, 2, uu, 1'b1));
        end
        fork
            send(0, 2, 2, 32'h200, uu);
            send(1, 2, 2, 32'h300, uu);
        join
        repeat (3) step();
        cmp_q("t2");
        for (int i = 1; i < obs_cyc.size(); i++) begin
            chk($sformatf("t2_gap%0d", i), 768'(obs_cyc[i] - obs_cyc[i-1]),
                768'((i % 2 == 0) ? 2 : 1));
        end
        chk("t2_cnts", 768'({pkt_cnt_0, pkt_cnt_1}), 768'({32'd2, 32'd2}));

        // 3: random backpressure on a 5-beat s1 packet
        obs.delete();
        expq.delete();
        uu = 128'h1234_0000_0000_0000_0000_0000_00FF_0000;
        for (int i = 0; i < 5; i++)
            expq.push_back(mk(1, 32'h400, i, 5, uu, 1'b1));
        done = 1'b0;
        fork
            begin
                send(1, 1, 5, 32'h400, uu);
                done = 1'b1;
            end
            begin
                int t;
                t = 0;
                while (!done && t < 400) begin
                    m_tready = 1'($urandom_range(0, 1));
                    chk("t3_s0rdy", 768'(s0_tready), 768'(0));
                    step();
                    t++;
                end
            end
        join
        m_tready = 1'b1;
        repeat (4) step();
        cmp_q("t3");
        chk("t3_cnts", 768'({pkt_cnt_0, pkt_cnt_1}), 768'({32'd2, 32'd3}));

        // 4: counter wrap
        force dut.pkt_cnt_1_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_1_q;
        step();
        chk("t4_preset", 768'(pkt_cnt_1), 768'(32'hFFFF_FFFF));
        send(1, 1, 1, 32'h500, '0);
        step();
        chk("t4_wrap", 768'(pkt_cnt_1), 768'(0));
        chk("t4_cnt0", 768'(pkt_cnt_0), 768'(2));

        // 5: reset mid-packet, then a clean s1 packet with tuser all ones
        rst();
        drive(1, mk(1, 32'h600, 0, 4, '0, 1'b0), 1'b1);
        step();
        step();
        drive(1, mk(1, 32'h600, 1, 4, '0, 1'b0), 1'b1);
        step();
        drive(1, mk(1, 32'h600, 2, 4, '0, 1'b0), 1'b1);
        chk("t5_mid_valid", 768'(m_tvalid), 768'(1));
        aresetn = 1'b0;
        #1;
        chk("t5_rst_out", 768'({m_tvalid, s0_tready, s1_tready}), 768'(0));
        chk("t5_rst_data", 768'(cur_out()), 768'(0));
        chk("t5_rst_cnt", 768'(pkt_cnt_1), 768'(0));
        rst();
        uu = '1;
        for (int i = 0; i < 3; i++)
            expq.push_back(mk(1, 32'h700, i, 3, uu, 1'b1));
        send(1, 1, 3, 32'h700, uu);
        repeat (3) step();
        cmp_q("t5");
        chk("t5_cnt", 768'({pkt_cnt_0, pkt_cnt_1}), 768'({32'd0, 32'd1}));

        // 6: all-ones tuser only differs in the source-port byte
        b = obs.size() > 0 ? obs[0] : '0;
        chk("t6_user", 768'(b.u),
            768'(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF04_FFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
